uart_tx_fifo: RTL

//   Write-side buffer directly upstream of the UART transmitter. Absorbs bytes from the
//   CPU/bus side, presents the head byte plus a start request to the transmitter, and

---
 rtl/uart_tx_fifo.sv | 64 ++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through circular FIFO feeding a UART transmitter.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ports ovf_clr, overflow).
module uart_tx_fifo #(
    parameter int DBITS     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DBITS-1:0]     wr_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    input  logic                 tx_ready,
    output logic                 tx_start,
    output logic [DBITS-1:0]     tx_data
`ifdef UART_TX_FIFO_OVF_EN
    ,
    input  logic                 ovf_clr,
    output logic                 overflow
`endif
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    logic [DBITS-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic                 push, pop;
    assign empty    = count == '0;
    assign full     = count == (ADDR_BITS + 1)'(DEPTH);
    assign tx_start = ~empty;
    assign tx_data  = mem[rd_ptr];
    assign pop      = tx_start & tx_ready;
    assign push     = wr_en & (~full | pop);
    always_ff @(posedge clk_100MHz) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                count <= count + 1'b1;
            else if (pop & ~push)
                count <= count - 1'b1;
        end
    end
`ifdef UART_TX_FIFO_OVF_EN
    // A dropped write beats a simultaneous clear.
    always_ff @(posedge clk_100MHz) begin
        if (reset)
            overflow <= 1'b0;
        else if (wr_en & full & ~pop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end
`endif
endmodule
